// File: rtl/ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle controller and its ALU decoder.
// Optional feature macro: CTRL_BNE_EN (adds bne through the BRANCH state).
package ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_ALU_WB   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // ALU-op class handed to the funct decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_is_branch(input logic [5:0] op);
`ifdef CTRL_BNE_EN
    return (op == OP_BEQ) || (op == OP_BNE);
`else
    return (op == OP_BEQ);
`endif
  endfunction

  function automatic logic op_decoded(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_J) || op_is_branch(op);
  endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Maps an ALU-op class plus funct to the 2-bit alu_ctrl code and a funct-illegal flag.
module ctrl_alu_dec
  import ctrl_fsm_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_ctrl,
  output logic       funct_illegal
);

  always_comb begin
    alu_ctrl      = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle MIPS-subset controller: registered state, combinational datapath controls.
// Optional feature macro: CTRL_BNE_EN (bne branches on ~zero; otherwise bne is illegal).
module ctrl_fsm
  import ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [1:0] alu_ctrl,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     r_state;
  logic [1:0] w_alu_op;
  logic [1:0] w_alu_ctrl;
  logic       w_funct_illegal;

  assign state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH:    r_state <= mem_ready ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          if ((opcode == OP_LW) || (opcode == OP_SW)) r_state <= ST_MEM_ADDR;
          else if (opcode == OP_RTYPE)                r_state <= ST_EXEC;
          else if (op_is_branch(opcode))              r_state <= ST_BRANCH;
          else if (opcode == OP_J)                    r_state <= ST_JUMP;
          else                                        r_state <= ST_FETCH;
        end
        ST_MEM_ADDR: r_state <= (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   r_state <= mem_ready ? ST_MEM_WB : ST_MEM_RD;
        ST_MEM_WB:   r_state <= ST_FETCH;
        ST_MEM_WR:   r_state <= mem_ready ? ST_FETCH : ST_MEM_WR;
        ST_EXEC:     r_state <= w_funct_illegal ? ST_FETCH : ST_ALU_WB;
        ST_ALU_WB:   r_state <= ST_FETCH;
        ST_BRANCH:   r_state <= ST_FETCH;
        ST_JUMP:     r_state <= ST_FETCH;
        default:     r_state <= ST_FETCH;
      endcase
    end
  end

  // Kept apart from the output block so the decoder path has no apparent loop
  always_comb begin
    case (r_state)
      ST_EXEC:   w_alu_op = ALUOP_FUNCT;
      ST_BRANCH: w_alu_op = ALUOP_SUB;
      default:   w_alu_op = ALUOP_ADD;
    endcase
  end

  ctrl_alu_dec u_alu_dec (
    .alu_op        (w_alu_op),
    .funct         (funct),
    .alu_ctrl      (w_alu_ctrl),
    .funct_illegal (w_funct_illegal)
  );

  always_comb begin
    alu_srcA   = 1'b0;
    alu_srcB   = SRCB_REG;
    alu_ctrl   = w_alu_ctrl;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          alu_srcB = SRCB_ONE;
        end else begin
          ir_write = 1'b0;
        end
      end
      ST_DECODE: begin
        alu_srcB = SRCB_SHIMM;
        illegal  = ~op_decoded(opcode);
      end
      ST_MEM_ADDR: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC: begin
        alu_srcA = 1'b1;
        illegal  = w_funct_illegal;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_srcA  = 1'b1;
        pc_source = 2'b01;
`ifdef CTRL_BNE_EN
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
`else
        pc_en     = zero;
`endif
      end
      ST_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      default: illegal = 1'b0;
    endcase
    // Reset overrides every control so no access or write leaks out mid-reset
    if (rst) begin
      alu_srcA   = 1'b0;
      alu_srcB   = SRCB_REG;
      alu_ctrl   = ALU_ADD;
      pc_en      = 1'b0;
      pc_source  = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
    end else begin
      alu_ctrl = alu_ctrl;
    end
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
- REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high. Clock port: clk. Reset port: rst.
- REQ-002 clk  in  1  rising-edge clock for all state.
- REQ-003 rst  in  1  synchronous active-high reset.
- REQ-004 opcode  in  6  instruction[31:26] from the instruction register.
- REQ-005 funct  in  6  instruction[5:0] from the instruction register.
- REQ-006 zero  in  1  ALU zero flag.
- REQ-007 mem_ready  in  1  memory access completes this cycle.
- REQ-008 alu_srcA  out  1  1=register A, 0=PC.
- REQ-009 alu_srcB  out  2  00=register B, 01=constant 1, 10=sign-extended imm, 11=shifted imm.
- REQ-010 alu_ctrl  out  2  00=ADD, 01=SUB, 10=AND, 11=OR.
- REQ-011 pc_en, pc_source[1:0], iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write  out  datapath strobes and selects.
- REQ-012 illegal  out  1  one-cycle pulse on an undecoded opcode or funct.
- REQ-013 state  out  4  current state, for debug.

Function
- REQ-014 States SHALL be: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP.
- REQ-015 FETCH: mem_read=1, iord=0. On mem_ready: ir_write=1, pc_en=1, alu_srcA=0, alu_srcB=01, ADD, pc_source=00, next DECODE. Otherwise hold in FETCH.
- REQ-016 DECODE: alu_srcA=0, alu_srcB=11, ADD (branch target precomputed). Next state by opcode:
  - lw 100011 or sw 101011 -> MEM_ADDR
  - R-type 000000 -> EXEC
  - beq 000100 -> BRANCH
  - j 000010 -> JUMP
  - any other opcode -> FETCH with illegal=1
- REQ-017 MEM_ADDR: alu_srcA=1, alu_srcB=10, ADD. Next MEM_RD for lw, MEM_WR for sw.
- REQ-018 MEM_RD: iord=1, mem_read=1. Hold until mem_ready, then MEM_WB.
- REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- REQ-020 MEM_WR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- REQ-021 EXEC: alu_srcA=1, alu_srcB=00. funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR. Next ALU_WB. Any other funct -> FETCH with illegal=1.
- REQ-022 ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- REQ-023 BRANCH: alu_srcA=1, alu_srcB=00, SUB, pc_source=01, pc_en=zero. Next FETCH.
- REQ-024 JUMP: pc_source=10, pc_en=1. Next FETCH.
- REQ-025 All outputs SHALL be Moore/Mealy combinational from state, inputs and opcode/funct. Unlisted strobes SHALL be 0 and unlisted selects SHALL be 0.
- REQ-026 Latency in cycles, with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - j 3
  - Each mem_ready=0 cycle adds one.
- REQ-027 mem_read and mem_write SHALL never be asserted together. Each SHALL stay asserted while waiting.

Reset
- REQ-028 When rst=1 at a clock edge, state SHALL become FETCH, regardless of current state or pending memory access.
- REQ-029 While rst=1, all strobes SHALL be 0, including pc_en, ir_write, reg_write, mem_read, mem_write and illegal.

Configuration
- REQ-030 Macro CTRL_BNE_EN.
  - Defined: opcode 000101 (bne) SHALL go DECODE -> BRANCH with pc_en = ~zero.
  - Undefined: opcode 000101 SHALL be illegal per REQ-016.

Structure
- REQ-031 A shared package SHALL hold the state enumeration, opcode/funct constants, and the alu_ctrl and alu_srcB encodings. The ALU wrapper SHALL use the same package.
- REQ-032 One sub-module, ctrl_alu_dec, SHALL map funct plus a 2-bit ALU-op class to alu_ctrl and the funct-illegal flag.

Verification
- REQ-033 After reset, lw with mem_ready held at 1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_write=1 only in the 5th cycle.
- REQ-034 beq with zero=1 -> pc_en=1 and pc_source=01 in BRANCH. With zero=0 -> pc_en=0. Both return to FETCH.
- REQ-035 sw with mem_ready=0 for 3 cycles in MEM_WR -> mem_write held for 4 cycles, then FETCH, mem_read never asserted.
- REQ-036 R-type with funct 100010 -> alu_ctrl=01 in EXEC. Funct 101010 -> illegal pulses one cycle, then FETCH, no reg_write.
- REQ-037 rst asserted mid MEM_RD -> next state FETCH and all strobes 0.
- REQ-038 Opcode 000101 with zero=0 -> pc_en=1 if CTRL_BNE_EN is defined. Otherwise illegal=1.
